hdlc_rx_deframer: RTL and testbench

//  Clocked, parametrised successor to the one-hot run-length classifier.

---
 rtl/hdlc_rx_pkg.sv | 29 ++
 rtl/hdlc_run_detector.sv | 60 ++++++
 rtl/hdlc_rx_deframer.sv | 204 ++++++++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_pkg
// Summary  : Shared types and constants for the HDLC receive deframer.
// Revision : 1.0 - initial release
// ============================================================================
package hdlc_rx_pkg;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        STUFF = 2'd1,
        FLAG  = 2'd2,
        ABORT = 2'd3
    } bit_class_t;

    // The delay pipe must hold a whole flag: leading 0 plus RUN_LEN+1 ones.
    localparam int PIPE_MARGIN = 2;

    function automatic int pipe_depth(input int run_len);
        return run_len + PIPE_MARGIN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdlc_run_detector.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_run_detector
// Summary  : Saturating ones-run counter; classifies each bit as data, stuffed
//            zero, flag or abort using the run length before the update.
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_run_detector
    import hdlc_rx_pkg::*;
#(
    parameter int RUN_LEN = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_vld,
    output bit_class_t bit_class
);

    localparam int c_sat   = RUN_LEN + 2;
    localparam int c_cnt_w = $clog2(c_sat + 1);
    localparam logic [c_cnt_w-1:0] c_stuff_at = c_cnt_w'(RUN_LEN);
    localparam logic [c_cnt_w-1:0] c_flag_at  = c_cnt_w'(RUN_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_sat_at   = c_cnt_w'(c_sat);

    logic [c_cnt_w-1:0] ones_cnt_q;
    logic [c_cnt_w-1:0] ones_cnt_d;

    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (bit_vld) begin
            if (!bit_in) begin
                ones_cnt_d = '0;
            end else if (ones_cnt_q != c_sat_at) begin
                ones_cnt_d = ones_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bit_class = DATA;
        if (!bit_in && (ones_cnt_q == c_stuff_at)) begin
            bit_class = STUFF;
        end else if (!bit_in && (ones_cnt_q == c_flag_at)) begin
            bit_class = FLAG;
        end else if (bit_in && (ones_cnt_q == c_flag_at)) begin
            bit_class = ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdlc_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_deframer
// Summary  : HDLC receive deframer: flag/abort detection, zero de-stuffing,
//            flag-deep delay pipe and LSB-first word assembly.
// Options  : HDLC_RX_STATS_EN enables the saturating st_* counters.
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_rx_deframer
    import hdlc_rx_pkg::*;
#(
    parameter int RUN_LEN = 5,
    parameter int WORD_W  = 8,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic [WORD_W-1:0] word_out,
    output logic              word_vld,
    output logic              in_frame,
    output logic              stuff_pulse,
    output logic              frame_end,
    output logic              align_err,
    output logic              abort_pulse,
    output logic [STAT_W-1:0] st_frames,
    output logic [STAT_W-1:0] st_aborts,
    output logic [STAT_W-1:0] st_align
);

    localparam int c_pipe_d = pipe_depth(RUN_LEN);
    localparam int c_pc_w   = $clog2(c_pipe_d + 1);
    localparam int c_bc_w   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_pc_w-1:0] c_pipe_full = c_pc_w'(c_pipe_d);
    localparam logic [c_bc_w-1:0] c_bit_last  = c_bc_w'(WORD_W - 1);

    bit_class_t bit_class;

    hdlc_run_detector #(.RUN_LEN(RUN_LEN)) u_run_detector (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .bit_class (bit_class)
    );

    rx_state_t            state_q, state_d;
    logic [c_pipe_d-1:0]  pipe_q, pipe_d;
    logic [c_pc_w-1:0]    pcnt_q, pcnt_d;
    logic [WORD_W-1:0]    sr_q, sr_d;
    logic [c_bc_w-1:0]    bcnt_q, bcnt_d;
    logic                 has_data_q, has_data_d;
    logic [WORD_W-1:0]    word_out_q, word_out_d;
    logic                 word_vld_q, word_vld_d;
    logic                 stuff_pulse_q, stuff_pulse_d;
    logic                 frame_end_q, frame_end_d;
    logic                 align_err_q, align_err_d;
    logic                 abort_pulse_q, abort_pulse_d;

    logic w_flag, w_abort, w_stuff, w_push, w_eject, w_shift_in;

    assign w_flag     = bit_vld && (bit_class == FLAG);
    assign w_abort    = bit_vld && (bit_class == ABORT);
    assign w_stuff    = bit_vld && (bit_class == STUFF);
    assign w_push     = bit_vld && (bit_class == DATA);
    assign w_eject    = w_push && (pcnt_q == c_pipe_full);
    assign w_shift_in = w_eject && (state_q == FRAME);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (w_flag)  state_d = FRAME;
            FRAME:   if (w_abort) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        stuff_pulse_d = w_stuff;
        frame_end_d   = w_flag && (state_q == FRAME) && has_data_q;
        align_err_d   = frame_end_d && (bcnt_q != '0);
        abort_pulse_d = w_abort && (state_q == FRAME);
    end

    // Flags and aborts flush the pipe, so flag bits never reach the assembler.
    always_comb begin
        pipe_d = pipe_q;
        pcnt_d = pcnt_q;
        if (w_flag || w_abort) begin
            pcnt_d = '0;
        end else if (w_push) begin
            pipe_d = {pipe_q[c_pipe_d-2:0], bit_in};
            if (pcnt_q != c_pipe_full) begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sr_d       = sr_q;
        bcnt_d     = bcnt_q;
        has_data_d = has_data_q;
        word_out_d = word_out_q;
        word_vld_d = 1'b0;
        if (w_flag || w_abort) begin
            sr_d       = '0;
            bcnt_d     = '0;
            has_data_d = 1'b0;
        end else if (w_shift_in) begin
            sr_d             = sr_q >> 1;
            sr_d[WORD_W-1]   = pipe_q[c_pipe_d-1];
            has_data_d       = 1'b1;
            if (bcnt_q == c_bit_last) begin
                word_out_d = sr_d;
                word_vld_d = 1'b1;
                bcnt_d     = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q        <= '0;
            pcnt_q        <= '0;
            sr_q          <= '0;
            bcnt_q        <= '0;
            has_data_q    <= 1'b0;
            word_out_q    <= '0;
            word_vld_q    <= 1'b0;
            stuff_pulse_q <= 1'b0;
            frame_end_q   <= 1'b0;
            align_err_q   <= 1'b0;
            abort_pulse_q <= 1'b0;
        end else begin
            pipe_q        <= pipe_d;
            pcnt_q        <= pcnt_d;
            sr_q          <= sr_d;
            bcnt_q        <= bcnt_d;
            has_data_q    <= has_data_d;
            word_out_q    <= word_out_d;
            word_vld_q    <= word_vld_d;
            stuff_pulse_q <= stuff_pulse_d;
            frame_end_q   <= frame_end_d;
            align_err_q   <= align_err_d;
            abort_pulse_q <= abort_pulse_d;
        end
    end

    assign word_out    = word_out_q;
    assign word_vld    = word_vld_q;
    assign in_frame    = (state_q == FRAME);
    assign stuff_pulse = stuff_pulse_q;
    assign frame_end   = frame_end_q;
    assign align_err   = align_err_q;
    assign abort_pulse = abort_pulse_q;

`ifdef HDLC_RX_STATS_EN
    logic [STAT_W-1:0] st_frames_q, st_frames_d;
    logic [STAT_W-1:0] st_aborts_q, st_aborts_d;
    logic [STAT_W-1:0] st_align_q,  st_align_d;

    always_comb begin
        st_frames_d = st_frames_q;
        st_aborts_d = st_aborts_q;
        st_align_d  = st_align_q;
        if (frame_end_d && !align_err_d && (st_frames_q != '1)) st_frames_d = st_frames_q + 1'b1;
        if (frame_end_d &&  align_err_d && (st_align_q  != '1)) st_align_d  = st_align_q  + 1'b1;
        if (abort_pulse_d && (st_aborts_q != '1))               st_aborts_d = st_aborts_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_frames_q <= '0;
            st_aborts_q <= '0;
            st_align_q  <= '0;
        end else begin
            st_frames_q <= st_frames_d;
            st_aborts_q <= st_aborts_d;
            st_align_q  <= st_align_d;
        end
    end

    assign st_frames = st_frames_q;
    assign st_aborts = st_aborts_q;
    assign st_align  = st_align_q;
`else
    assign st_frames = '0;
    assign st_aborts = '0;
    assign st_align  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlc_rx_deframer
// Summary  : Scoreboard bench for hdlc_rx_deframer (RUN_LEN=5, WORD_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdlc_rx_deframer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_vld;
    logic [7:0]  word_out;
    logic        word_vld, in_frame, stuff_pulse, frame_end, align_err, abort_pulse;
    logic [15:0] st_frames, st_aborts, st_align;

    hdlc_rx_deframer #(.RUN_LEN(5), .WORD_W(8), .STAT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .word_out    (word_out),
        .word_vld    (word_vld),
        .in_frame    (in_frame),
        .stuff_pulse (stuff_pulse),
        .frame_end   (frame_end),
        .align_err   (align_err),
        .abort_pulse (abort_pulse),
        .st_frames   (st_frames),
        .st_aborts   (st_aborts),
        .st_align    (st_align)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_words[$];
    logic [7:0] got_words[$];
    logic       got_align[$];
    int n_stuff = 0, n_fe = 0, n_abort = 0, n_coinc = 0;

    int          tb_ones;
    int          tb_stuffs = 0;
    logic [15:0] exp_frames, exp_aborts, exp_align;

    always @(negedge clk) begin
        if (word_vld) got_words.push_back(word_out);
        if (stuff_pulse) n_stuff++;
        if (frame_end) begin
            n_fe++;
            got_align.push_back(align_err);
        end
        if (abort_pulse) n_abort++;
        if (word_vld && (frame_end || abort_pulse)) n_coinc++;
    end

    task automatic send_bit(input logic b);
        bit_in  = b;
        bit_vld = 1'b1;
        @(negedge clk);
        bit_vld = 1'b0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_raw(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic send_flag();
        send_raw(16'h007E, 8);
        tb_ones = 0;
    endtask

    // Independent transmit model: insert a 0 after five payload ones.
    task automatic send_pl_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(v[i]);
            tb_ones = v[i] ? tb_ones + 1 : 0;
            if (tb_ones == 5) begin
                send_bit(1'b0);
                tb_stuffs++;
                tb_ones = 0;
            end
        end
    endtask

    task automatic send_pl_byte(input logic [7:0] b);
        exp_words.push_back(b);
        send_pl_bits({8'h00, b}, 8);
    endtask

    task automatic do_reset();
        bit_vld = 1'b0;
        bit_in  = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        tb_ones    = 0;
        exp_frames = '0;
        exp_aborts = '0;
        exp_align  = '0;
        got_words.delete();
        got_align.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({word_vld, in_frame, stuff_pulse, frame_end, align_err, abort_pulse} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {word_vld, in_frame, stuff_pulse, frame_end, align_err, abort_pulse});
        end
        checks++;
        if (word_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_word: got %h expected 00", word_out);
        end
        checks++;
        if ({st_frames, st_aborts, st_align} !== 48'h0) begin
            errors++;
            $display("FAIL reset_stats: got %h expected 0", {st_frames, st_aborts, st_align});
        end
    endtask

    task automatic test_basic();
        int f0 = n_fe, s0 = n_stuff;
        logic [7:0] gw, ew;
        got_align.delete();
        send_flag(); send_pl_byte(8'hA5); send_flag(); idle(4);
        exp_frames++;
        while (exp_words.size() != 0 && got_words.size() != 0) begin
            ew = exp_words.pop_front(); gw = got_words.pop_front(); checks++;
            if (gw !== ew) begin errors++; $display("FAIL basic_word: got %h expected %h", gw, ew); end
        end
        checks++;
        if (exp_words.size() != got_words.size()) begin
            errors++;
            $display("FAIL basic_word_count: got %0d extra expected %0d missing", got_words.size(), exp_words.size());
        end
        exp_words.delete(); got_words.delete();
        checks++;
        if (n_fe - f0 != 1 || got_align.size() != 1 || got_align[0] !== 1'b0) begin
            errors++; $display("FAIL basic_frame_end: got %0d ends expected 1 with align_err 0", n_fe - f0);
        end
        checks++;
        if (n_stuff - s0 != 0) begin errors++; $display("FAIL basic_stuff: got %0d expected 0", n_stuff - s0); end
`ifdef HDLC_RX_STATS_EN
        checks++;
        if ({st_frames, st_aborts, st_align} !== {exp_frames, exp_aborts, exp_align}) begin
            errors++; $display("FAIL basic_stats: got %h expected %h", {st_frames, st_aborts, st_align}, {exp_frames, exp_aborts, exp_align});
        end
`endif
    endtask

    task automatic test_stuff();
        int f0 = n_fe, s0 = n_stuff, t0 = tb_stuffs;
        logic [7:0] gw, ew;
        got_align.delete();
        send_flag(); send_pl_byte(8'hFF); send_flag(); idle(4);
        exp_frames++;
        while (exp_words.size() != 0 && got_words.size() != 0) begin
            ew = exp_words.pop_front(); gw = got_words.pop_front(); checks++;
            if (gw !== ew) begin errors++; $display("FAIL stuff_word: got %h expected %h", gw, ew); end
        end
        checks++;
        if (exp_words.size() != got_words.size()) begin
            errors++;
            $display("FAIL stuff_word_count: got %0d extra expected %0d missing", got_words.size(), exp_words.size());
        end
        exp_words.delete(); got_words.delete();
        checks++;
        if (n_stuff - s0 != tb_stuffs - t0) begin
            errors++; $display("FAIL stuff_pulses: got %0d expected %0d", n_stuff - s0, tb_stuffs - t0);
        end
        checks++;
        if (n_fe - f0 != 1 || got_align.size() != 1 || got_align[0] !== 1'b0) begin
            errors++; $display("FAIL stuff_frame_end: got %0d ends expected 1 with align_err 0", n_fe - f0);
        end
`ifdef HDLC_RX_STATS_EN
        checks++;
        if ({st_frames, st_aborts, st_align} !== {exp_frames, exp_aborts, exp_align}) begin
            errors++; $display("FAIL stuff_stats: got %h expected %h", {st_frames, st_aborts, st_align}, {exp_frames, exp_aborts, exp_align});
        end
`endif
    endtask

    task automatic test_abort();
        int f0 = n_fe, a0 = n_abort;
        send_flag();
        send_raw(16'h0002, 3);
        send_raw(16'h007F, 7);
        idle(4);
        exp_aborts++;
        checks++;
        if (n_abort - a0 != 1) begin errors++; $display("FAIL abort_pulse: got %0d expected 1", n_abort - a0); end
        checks++;
        if (in_frame !== 1'b0) begin errors++; $display("FAIL abort_in_frame: got %b expected 0", in_frame); end
        checks++;
        if (got_words.size() != 0) begin errors++; $display("FAIL abort_words: got %0d expected 0", got_words.size()); end
        send_flag(); idle(4);
        checks++;
        if (in_frame !== 1'b1) begin errors++; $display("FAIL abort_reenter: got %b expected 1", in_frame); end
        checks++;
        if (n_fe - f0 != 0) begin errors++; $display("FAIL abort_frame_end: got %0d expected 0", n_fe - f0); end
        got_words.delete();
`ifdef HDLC_RX_STATS_EN
        checks++;
        if ({st_frames, st_aborts, st_align} !== {exp_frames, exp_aborts, exp_align}) begin
            errors++; $display("FAIL abort_stats: got %h expected %h", {st_frames, st_aborts, st_align}, {exp_frames, exp_aborts, exp_align});
        end
`endif
    endtask

    task automatic test_align();
        int f0 = n_fe;
        logic [7:0] gw, ew;
        got_align.delete();
        send_flag(); send_pl_byte(8'h3C); send_pl_bits(16'h0009, 4); send_flag(); idle(4);
        exp_align++;
        while (exp_words.size() != 0 && got_words.size() != 0) begin
            ew = exp_words.pop_front(); gw = got_words.pop_front(); checks++;
            if (gw !== ew) begin errors++; $display("FAIL align_word: got %h expected %h", gw, ew); end
        end
        checks++;
        if (exp_words.size() != got_words.size()) begin
            errors++;
            $display("FAIL align_word_count: got %0d extra expected %0d missing", got_words.size(), exp_words.size());
        end
        exp_words.delete(); got_words.delete();
        checks++;
        if (n_fe - f0 != 1 || got_align.size() != 1 || got_align[0] !== 1'b1) begin
            errors++; $display("FAIL align_frame_end: got %0d ends expected 1 with align_err 1", n_fe - f0);
        end
`ifdef HDLC_RX_STATS_EN
        checks++;
        if ({st_frames, st_aborts, st_align} !== {exp_frames, exp_aborts, exp_align}) begin
            errors++; $display("FAIL align_stats: got %h expected %h", {st_frames, st_aborts, st_align}, {exp_frames, exp_aborts, exp_align});
        end
`endif
    endtask

    task automatic test_back_to_back();
        int f0;
        do_reset();
        f0 = n_fe;
        send_flag(); idle(2);
        checks++;
        if (in_frame !== 1'b1) begin errors++; $display("FAIL b2b_enter: got %b expected 1", in_frame); end
        send_flag(); send_flag(); idle(4);
        checks++;
        if (n_fe - f0 != 0 || got_words.size() != 0) begin
            errors++; $display("FAIL b2b_empty: got %0d ends %0d words expected 0 0", n_fe - f0, got_words.size());
        end
        checks++;
        if (in_frame !== 1'b1) begin errors++; $display("FAIL b2b_stay: got %b expected 1", in_frame); end
    endtask

    // Random frames sharing flags; expected words pushed as they are sent.
    task automatic test_random_frames();
        int f0 = n_fe, s0 = n_stuff, t0 = tb_stuffs, nf = 0;
        logic [7:0] gw, ew;
        got_align.delete();
        send_flag();
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) send_pl_byte(8'($urandom_range(0, 255)));
            send_flag();
            nf++;
            exp_frames++;
        end
        idle(4);
        while (exp_words.size() != 0 && got_words.size() != 0) begin
            ew = exp_words.pop_front(); gw = got_words.pop_front(); checks++;
            if (gw !== ew) begin errors++; $display("FAIL random_word: got %h expected %h", gw, ew); end
        end
        checks++;
        if (exp_words.size() != got_words.size()) begin
            errors++;
            $display("FAIL random_word_count: got %0d extra expected %0d missing", got_words.size(), exp_words.size());
        end
        exp_words.delete(); got_words.delete();
        checks++;
        if (n_fe - f0 != nf) begin errors++; $display("FAIL random_frame_end: got %0d expected %0d", n_fe - f0, nf); end
        checks++;
        if (n_stuff - s0 != tb_stuffs - t0) begin
            errors++; $display("FAIL random_stuff: got %0d expected %0d", n_stuff - s0, tb_stuffs - t0);
        end
`ifdef HDLC_RX_STATS_EN
        checks++;
        if ({st_frames, st_aborts, st_align} !== {exp_frames, exp_aborts, exp_align}) begin
            errors++; $display("FAIL random_stats: got %h expected %h", {st_frames, st_aborts, st_align}, {exp_frames, exp_aborts, exp_align});
        end
`endif
    endtask

    task automatic test_reset_mid();
        send_flag();
        send_raw(16'h000D, 4);
        do_reset();
        checks++;
        if ({word_out, word_vld, in_frame, stuff_pulse, frame_end, align_err, abort_pulse} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {word_out, word_vld, in_frame, stuff_pulse, frame_end, align_err, abort_pulse});
        end
        checks++;
        if ({st_frames, st_aborts, st_align} !== 48'h0) begin
            errors++; $display("FAIL reset_mid_stats: got %h expected 0", {st_frames, st_aborts, st_align});
        end
        send_raw(16'h00A5, 8);
        idle(4);
        checks++;
        if (got_words.size() != 0 || in_frame !== 1'b0) begin
            errors++; $display("FAIL reset_mid_hunt: got %0d words in_frame %b expected 0 0", got_words.size(), in_frame);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_coinc != 0) begin errors++; $display("FAIL word_vs_boundary: got %0d overlaps expected 0", n_coinc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        bit_in  = 1'b0;
        bit_vld = 1'b0;
        tb_ones = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stuff();
        test_abort();
        test_align();
        test_back_to_back();
        test_random_frames();
        test_reset_mid();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
